hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock; all state updates on posedge clk.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-003 SHALL have inputs id_src1[3:0], id_src2[3:0], id_src1_valid, id_src2_valid: decode-stage source registers and their use flags.
REQ-004 SHALL have inputs ex_dest[3:0], ex_wb_en, ex_mem_r_en: destination, writeback enable and load flag of the instruction in EX.
REQ-005 SHALL have inputs mem_dest[3:0], mem_wb_en: destination and writeback enable of the instruction in MEM.
REQ-006 SHALL have input branch_taken, 1 bit: branch resolved taken in EX this cycle.
REQ-007 SHALL have inputs mem_req and mem_ready, 1 bit each: MEM-stage access request and memory completion.
REQ-008 SHALL have outputs pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_freeze, 1 bit each: pipeline register controls; flush has priority over freeze at each register.
REQ-009 SHALL have outputs mem_timeout (1 bit, sticky error) and stall_cycles[15:0] (performance counter).

Function
REQ-010 SHALL compute all freeze/flush outputs combinationally from current inputs and registered state.
REQ-011 SHALL detect a RAW hit when a valid source equals the destination of an EX or MEM instruction with wb_en=1; register 15 SHALL be excluded from detection.
REQ-012 SHALL resolve a data hazard as follows: pc_freeze=1, ifid_freeze=1, idex_flush=1 (bubble); all other outputs 0.
REQ-013 SHALL resolve branch_taken=1 as follows: ifid_flush=1, idex_flush=1; branch_taken SHALL override any data-hazard stall in the same cycle.
REQ-014 SHALL implement a memory FSM with states IDLE, WAIT and ERR.
REQ-015 SHALL transition IDLE->WAIT when mem_req=1 and mem_ready=0; WAIT->IDLE when mem_ready=1; WAIT->ERR when the wait count reaches 255; ERR SHALL be exited only by reset.
REQ-016 SHALL assert all seven freeze outputs while (IDLE and mem_req and !mem_ready) or WAIT; during a memory freeze all flushes SHALL be 0; memory freeze has highest priority.
REQ-017 SHALL implement the wait counter as an 8-bit register, cleared on entry to WAIT and incremented once per WAIT cycle.
REQ-018 SHALL assert mem_timeout=1 in ERR, together with all freezes held at 1.
REQ-019 SHALL latch branch_taken asserted during a memory freeze into flush_pending; on the first unfrozen cycle it SHALL drive ifid_flush=idex_flush=1 and then clear flush_pending.
REQ-020 SHALL increment stall_cycles on every cycle with pc_freeze=1; the counter SHALL saturate at 16'hFFFF.
REQ-021 SHALL treat mem_ready=1 in the same cycle as mem_req=1 in IDLE as zero-wait: no freeze, and the FSM SHALL stay in IDLE.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force the FSM to IDLE and clear the wait counter, flush_pending, mem_timeout and stall_cycles.
REQ-023 SHALL, on rst_n deasserting mid-WAIT, abandon the pending access; all outputs SHALL be 0 with no hazard inputs active.

Configuration
REQ-024 SHALL, with FORWARDING_EN defined, stall on RAW hits only when ex_mem_r_en=1 (load-use against EX); MEM-stage and non-load EX hits SHALL cause no stall.
REQ-025 SHALL, without FORWARDING_EN, stall on every RAW hit per REQ-011.

Verification
REQ-026 Bench SHALL show: id_src1=3 valid, ex_dest=3, ex_wb_en=1, ex_mem_r_en=0 -> stall for 1 cycle (pc_freeze, ifid_freeze, idex_flush) without FORWARDING_EN; no stall with it.
REQ-027 Bench SHALL show: ex_dest=5, ex_mem_r_en=1, id_src2=5 valid, FORWARDING_EN defined -> exactly one bubble cycle, stall_cycles increments by 1.
REQ-028 Bench SHALL show: branch_taken=1 together with an active RAW hit -> ifid_flush=1, idex_flush=1, pc_freeze=0.
REQ-029 Bench SHALL show: mem_req=1, mem_ready low for 4 cycles -> all freezes high for 4 cycles; branch_taken pulsed during the wait -> flush on the first released cycle only.
REQ-030 Bench SHALL show: mem_ready held 0 for 300 cycles -> mem_timeout=1 after 255 WAIT cycles and freezes stuck; rst_n=0 -> all outputs 0, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX/MEM hazard-information bus and the pipeline
// control outputs of hazard_ctrl.
//   master : pipeline side, drives the hazard inputs and receives the controls
//   slave  : hazard_ctrl side
// Signals:
//   id_src1/2, id_src1/2_valid        decode-stage sources and use flags
//   ex_dest, ex_wb_en, ex_mem_r_en    EX instruction destination/write/load
//   mem_dest, mem_wb_en               MEM instruction destination/write
//   branch_taken                      branch resolved taken in EX
//   mem_req, mem_ready                MEM-stage access request / completion
//   pc_freeze .. memwb_freeze         pipeline register freeze/flush controls
//   mem_timeout                       sticky memory timeout error
//   stall_cycles                      saturating pc_freeze cycle counter
interface hazard_ctrl_if;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_src1_valid;
  logic        id_src2_valid;
  logic [3:0]  ex_dest;
  logic        ex_wb_en;
  logic        ex_mem_r_en;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_freeze;
  logic        ifid_freeze;
  logic        ifid_flush;
  logic        idex_freeze;
  logic        idex_flush;
  logic        exmem_freeze;
  logic        memwb_freeze;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output id_src1, id_src2, id_src1_valid, id_src2_valid,
           ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
           exmem_freeze, memwb_freeze, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_src1_valid, id_src2_valid,
           ex_dest, ex_wb_en, ex_mem_r_en, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
           exmem_freeze, memwb_freeze, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller. Detects RAW data hazards against
// EX/MEM, applies branch flushes, and freezes the whole pipeline while a
// memory access is outstanding (IDLE/WAIT/ERR memory FSM with 255-cycle
// timeout). Counts pc_freeze cycles in a saturating 16-bit counter.
// Ports:
//   clk   pipeline clock
//   rst_n asynchronous active-low reset
//   hz    hazard_ctrl_if.slave bus (hazard inputs, pipeline controls)
// Build option: FORWARDING_EN -- when defined, only load-use hits against
// EX stall; otherwise every RAW hit against EX or MEM stalls.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_e;

  mem_state_e  state_q;
  logic [7:0]  wait_cnt_q;
  logic        flush_pending_q;
  logic        mem_timeout_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic data_hazard;
  logic mem_freeze;
  logic pc_freeze_c, ifid_freeze_c, ifid_flush_c, idex_freeze_c;
  logic idex_flush_c, exmem_freeze_c, memwb_freeze_c;

  // Register 15 is never tracked as a dependency.
  function automatic logic raw_hit(input logic [3:0] src, input logic src_v,
                                   input logic [3:0] dst, input logic wb_en);
    return src_v && wb_en && (src != 4'hF) && (src == dst);
  endfunction

`ifdef FORWARDING_EN
  assign data_hazard = hz.ex_mem_r_en &&
      (raw_hit(hz.id_src1, hz.id_src1_valid, hz.ex_dest, hz.ex_wb_en) ||
       raw_hit(hz.id_src2, hz.id_src2_valid, hz.ex_dest, hz.ex_wb_en));
`else
  assign data_hazard =
      raw_hit(hz.id_src1, hz.id_src1_valid, hz.ex_dest,  hz.ex_wb_en)  ||
      raw_hit(hz.id_src2, hz.id_src2_valid, hz.ex_dest,  hz.ex_wb_en)  ||
      raw_hit(hz.id_src1, hz.id_src1_valid, hz.mem_dest, hz.mem_wb_en) ||
      raw_hit(hz.id_src2, hz.id_src2_valid, hz.mem_dest, hz.mem_wb_en);
`endif

  // The cycle in which mem_ready arrives completes the access, so the
  // pipeline is released in that cycle rather than one cycle later.
  assign mem_freeze = (state_q == ERR) ||
                      ((state_q == WAIT) && !hz.mem_ready) ||
                      ((state_q == IDLE) && hz.mem_req && !hz.mem_ready);

  // Priority: memory freeze > branch flush (current or pending) > data stall.
  always_comb begin
    pc_freeze_c    = 1'b0;
    ifid_freeze_c  = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_freeze_c  = 1'b0;
    idex_flush_c   = 1'b0;
    exmem_freeze_c = 1'b0;
    memwb_freeze_c = 1'b0;
    if (mem_freeze) begin
      pc_freeze_c    = 1'b1;
      ifid_freeze_c  = 1'b1;
      idex_freeze_c  = 1'b1;
      exmem_freeze_c = 1'b1;
      memwb_freeze_c = 1'b1;
    end else if (hz.branch_taken || flush_pending_q) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (data_hazard) begin
      pc_freeze_c   = 1'b1;
      ifid_freeze_c = 1'b1;
      idex_flush_c  = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_freeze_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      mem_timeout_q   <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;

      if (mem_freeze && hz.branch_taken) begin
        flush_pending_q <= 1'b1;
      end else if (!mem_freeze) begin
        flush_pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (hz.mem_req && !hz.mem_ready) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (hz.mem_ready) begin
            state_q <= IDLE;
          end else if (wait_cnt_q == 8'd254) begin
            // 255th WAIT cycle without completion
            state_q       <= ERR;
            wait_cnt_q    <= 8'd255;
            mem_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ERR:     state_q <= ERR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hz.pc_freeze    = pc_freeze_c;
  assign hz.ifid_freeze  = ifid_freeze_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.idex_freeze  = idex_freeze_c;
  assign hz.idex_flush   = idex_flush_c;
  assign hz.exmem_freeze = exmem_freeze_c;
  assign hz.memwb_freeze = memwb_freeze_c;
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver applies one input vector per
// cycle, predicts the outputs from a behavioural model and queues them; the
// monitor compares on the falling edge.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  typedef struct {
    int unsigned src1, src2, exd, memd;
    bit v1, v2, ex_wb, ex_ld, mem_wb, br, req, rdy;
  } in_t;

  // ctl = {pc_fz, ifid_fz, ifid_fl, idex_fz, idex_fl, exmem_fz, memwb_fz, timeout}
  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_busy, m_dead, m_pend;
  int unsigned m_waited, m_stalls;

  function automatic in_t quiet();
    in_t s;
    s.src1 = 0; s.src2 = 0; s.exd = 0; s.memd = 0;
    s.v1 = 0; s.v2 = 0; s.ex_wb = 0; s.ex_ld = 0; s.mem_wb = 0;
    s.br = 0; s.req = 0; s.rdy = 0;
    return s;
  endfunction

  function automatic bit depends(int unsigned src, bit used, int unsigned dst, bit writes);
    return used && writes && (src == dst) && (src != 15);
  endfunction

  task automatic apply(input in_t s);
    bus.id_src1 = 4'(s.src1);  bus.id_src2 = 4'(s.src2);
    bus.id_src1_valid = s.v1;  bus.id_src2_valid = s.v2;
    bus.ex_dest = 4'(s.exd);   bus.ex_wb_en = s.ex_wb; bus.ex_mem_r_en = s.ex_ld;
    bus.mem_dest = 4'(s.memd); bus.mem_wb_en = s.mem_wb;
    bus.branch_taken = s.br;   bus.mem_req = s.req; bus.mem_ready = s.rdy;
  endtask

  task automatic step(input in_t s);
    bit stall, frozen, pc;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(s);
`ifdef FORWARDING_EN
    stall = s.ex_ld && (depends(s.src1, s.v1, s.exd, s.ex_wb) ||
                        depends(s.src2, s.v2, s.exd, s.ex_wb));
`else
    stall = depends(s.src1, s.v1, s.exd, s.ex_wb) || depends(s.src2, s.v2, s.exd, s.ex_wb) ||
            depends(s.src1, s.v1, s.memd, s.mem_wb) || depends(s.src2, s.v2, s.memd, s.mem_wb);
`endif
    frozen = m_dead || (m_busy ? !s.rdy : (s.req && !s.rdy));
    if (frozen)                e.ctl = 8'b1101_0110;
    else if (s.br || m_pend)   e.ctl = 8'b0010_1000;
    else if (stall)            e.ctl = 8'b1100_1000;
    else                       e.ctl = 8'b0000_0000;
    e.ctl[0] = m_dead;
    e.cnt = 16'(m_stalls);
    exp_q.push_back(e);
    pc = e.ctl[7];
    // advance model
    if (pc && m_stalls < 65535) m_stalls++;
    if (frozen && s.br) m_pend = 1;
    else if (!frozen)   m_pend = 0;
    if (!m_dead) begin
      if (m_busy) begin
        if (s.rdy) m_busy = 0;
        else begin
          m_waited++;
          if (m_waited == 255) begin m_dead = 1; m_busy = 0; end
        end
      end else if (s.req && !s.rdy) begin
        m_busy = 1; m_waited = 0;
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      apply(quiet());
      m_busy = 0; m_dead = 0; m_pend = 0; m_waited = 0; m_stalls = 0;
      e.ctl = '0;
      e.cnt = '0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus.pc_freeze, bus.ifid_freeze, bus.ifid_flush, bus.idex_freeze,
               bus.idex_flush, bus.exmem_freeze, bus.memwb_freeze, bus.mem_timeout};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
        end
        checks++;
        if (bus.stall_cycles !== e.cnt) begin
          errors++;
          $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, bus.stall_cycles, e.cnt);
        end
      end
    end
  end

  initial begin
    in_t s;
    apply(quiet());
    reset_cycles(2);

    // RAW hit against EX (non-load), then released
    s = quiet(); s.src1 = 3; s.v1 = 1; s.exd = 3; s.ex_wb = 1;
    step(s); step(quiet());
    // register 15 never hazards
    s = quiet(); s.src1 = 15; s.v1 = 1; s.exd = 15; s.ex_wb = 1; s.ex_ld = 1;
    step(s);
    // MEM-stage hit
    s = quiet(); s.src2 = 7; s.v2 = 1; s.memd = 7; s.mem_wb = 1;
    step(s);
    // load-use against EX
    s = quiet(); s.src2 = 5; s.v2 = 1; s.exd = 5; s.ex_wb = 1; s.ex_ld = 1;
    step(s); step(quiet());
    // branch with simultaneous RAW hit
    s = quiet(); s.src1 = 2; s.v1 = 1; s.exd = 2; s.ex_wb = 1; s.ex_ld = 1; s.br = 1;
    step(s); step(quiet());
    // zero-wait access
    s = quiet(); s.req = 1; s.rdy = 1;
    step(s); step(quiet());
    // 4-cycle memory wait with branch pulsed mid-wait
    for (int i = 0; i < 4; i++) begin
      s = quiet(); s.req = 1; s.br = (i == 1);
      step(s);
    end
    s = quiet(); s.req = 1; s.rdy = 1;
    step(s); step(quiet()); step(quiet());
    // reset while waiting abandons the access
    s = quiet(); s.req = 1;
    step(s); step(s); step(s);
    reset_cycles(2);
    step(quiet()); step(quiet());

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.src1 = $urandom_range(0, 15); s.src2 = $urandom_range(0, 15);
      s.exd = $urandom_range(0, 15);  s.memd = $urandom_range(0, 15);
      s.v1 = 1'($urandom); s.v2 = 1'($urandom);
      s.ex_wb = 1'($urandom); s.ex_ld = 1'($urandom); s.mem_wb = 1'($urandom);
      s.br = ($urandom_range(0, 7) == 0);
      s.req = ($urandom_range(0, 3) == 0);
      s.rdy = ($urandom_range(0, 2) != 0);
      step(s);
    end

    // timeout: ready never arrives; run on to saturate stall_cycles
    reset_cycles(1);
    s = quiet(); s.req = 1;
    for (int i = 0; i < 300; i++) step(s);
    s = quiet();
    for (int i = 0; i < 65300; i++) step(s);
    reset_cycles(2);
    step(quiet()); step(quiet());

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
